// File: rtl/soma_serial_8bits.sv
// -----------------------------------------------------------------------------
// soma_serial_8bits
//
// Bit-serial 8-bit adder. A single 1-bit full adder and a carry register add
// the two operands one bit per clock, least significant bit first. After the
// operands are accepted, the result is ready eight clocks later. It is then
// held on S/Cout until the next addition completes.
//
// Optional feature: define SOMA_OVERFLOW_EN to add the signed overflow port V.
//
// Ports:
//   clk    in   1  rising-edge clock for all state
//   rst_n  in   1  synchronous active-low reset
//   start  in   1  begin an addition (only looked at while idle)
//   A      in   8  augend, captured when start is accepted
//   B      in   8  addend, captured when start is accepted
//   Cin    in   1  carry-in, captured when start is accepted
//   S      out  8  registered sum
//   Cout   out  1  registered final carry-out
//   busy   out  1  high while an addition is in progress (SHIFT and DONE)
//   done   out  1  one-cycle pulse marking S/Cout (and V) valid
//   V      out  1  signed overflow flag (only with SOMA_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module soma_serial_8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout,
  output logic       busy,
  output logic       done
`ifdef SOMA_OVERFLOW_EN
  ,
  output logic       V
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  a_sh;
  logic [7:0]  b_sh;
  logic [7:0]  res;
  logic [2:0]  cnt;
  logic        carry;
  logic        sum_bit;
  logic        carry_out;

  // The single full adder works on the current LSBs of the captured operands
  // and the running carry.
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_out = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

  // State register. Reset forces IDLE and overrides any start request on the
  // same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start only matters in IDLE. DONE always lasts exactly
  // one cycle, so a held start cannot sneak in a new operation while busy.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == 3'd7) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs come straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath.
  // Operands are copied into private shift registers on the accepting edge,
  // so the result does not depend on A/B/Cin after that edge.
  // Sum bits build up in res, entering from the MSB side.
  // S/Cout (and V) are written only on the last shift edge. This keeps the
  // previous result visible for the whole of the next operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= 8'h00;
      b_sh  <= 8'h00;
      res   <= 8'h00;
      cnt   <= 3'd0;
      carry <= 1'b0;
      S     <= 8'h00;
      Cout  <= 1'b0;
`ifdef SOMA_OVERFLOW_EN
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= 3'd0;
          end
        end
        SHIFT: begin
          res   <= {sum_bit, res[7:1]};
          a_sh  <= {1'b0, a_sh[7:1]};
          b_sh  <= {1'b0, b_sh[7:1]};
          carry <= carry_out;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            S    <= {sum_bit, res[7:1]};
            Cout <= carry_out;
`ifdef SOMA_OVERFLOW_EN
            // Signed overflow is the carry into bit 7 (the running carry on
            // this edge) XOR the carry out of bit 7.
            V    <= carry ^ carry_out;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soma_serial_8bits.sv
// -----------------------------------------------------------------------------
// tb_soma_serial_8bits
//
// Directed self-checking bench for soma_serial_8bits. Each expected value is a
// hand-computed constant. Outputs are sampled on the falling clock edge.
// Build with SOMA_OVERFLOW_EN defined to also exercise the V flag.
// -----------------------------------------------------------------------------
module tb_soma_serial_8bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout;
  logic       busy;
  logic       done;
`ifdef SOMA_OVERFLOW_EN
  logic       V;
`endif

  int assertCount = 0;
  int failCount   = 0;

  soma_serial_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout),
    .busy  (busy),
    .done  (done)
`ifdef SOMA_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: stop the run if it hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts each check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one addition from IDLE.
  // Checks: the 8-clock latency, the result, and that done is a single-cycle
  // pulse.
  task automatic applyStimulus(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic cin,
                               input logic [7:0] expS, input logic expCout);
    int cycles;
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, 32'd8);
    checkOutput({tag, "_S"}, {24'd0, S}, {24'd0, expS});
    checkOutput({tag, "_Cout"}, {31'd0, Cout}, {31'd0, expCout});
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_Shold"}, {24'd0, S}, {24'd0, expS});
  endtask

  initial begin
    int cycles;
    int doneSeen;

    // Hold reset with start asserted; the start request must be ignored.
    rst_n = 1'b0; start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_S", {24'd0, S}, 32'h00);
    checkOutput("rst_Cout", {31'd0, Cout}, 32'd0);
`ifdef SOMA_OVERFLOW_EN
    checkOutput("rst_V", {31'd0, V}, 32'd0);
`endif
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_hold", {31'd0, busy}, 32'd0);

    // Basic additions.
    applyStimulus("add3C0F", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    applyStimulus("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    applyStimulus("addFFFF1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Idle with start low leaves the result untouched.
    repeat (3) @(negedge clk);
    checkOutput("idle_S", {24'd0, S}, 32'hFF);
    checkOutput("idle_Cout", {31'd0, Cout}, 32'd1);

    // Reset in the middle of SHIFT (counter=4) aborts the operation.
    @(negedge clk);
    A = 8'h05; B = 8'h06; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    checkOutput("mid_Shold", {24'd0, S}, 32'hFF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_S", {24'd0, S}, 32'h00);
    checkOutput("abort_Cout", {31'd0, Cout}, 32'd0);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort_nodone", doneSeen, 32'd0);

    // Change the inputs three clocks after acceptance; the captured values
    // must still be used.
    @(negedge clk);
    A = 8'h80; B = 8'h80; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'h00; B = 8'h00;
    cycles = 2;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("chg_latency", cycles, 32'd8);
    checkOutput("chg_S", {24'd0, S}, 32'h00);
    checkOutput("chg_Cout", {31'd0, Cout}, 32'd1);
`ifdef SOMA_OVERFLOW_EN
    checkOutput("chg_V", {31'd0, V}, 32'd1);
`endif
    @(negedge clk);

    // Keep start high all the time: one result every 10 clocks.
    @(negedge clk);
    A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
    cycles = 0;
    while (done !== 1'b1 && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("thr_first", cycles, 32'd9);
    checkOutput("thr_S1", {24'd0, S}, 32'h02);
    for (int k = 0; k < 2; k++) begin
      cycles = 0;
      do begin
        @(negedge clk);
        cycles++;
      end while (done !== 1'b1 && cycles < 30);
      checkOutput("thr_period", cycles, 32'd10);
      checkOutput("thr_S", {24'd0, S}, 32'h02);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("thr_stop", {31'd0, busy}, 32'd0);

    // Signed overflow cases.
    applyStimulus("ovf7F01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SOMA_OVERFLOW_EN
    checkOutput("ovf7F01_V", {31'd0, V}, 32'd1);
`endif
    applyStimulus("ovf1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
`ifdef SOMA_OVERFLOW_EN
    checkOutput("ovf1020_V", {31'd0, V}, 32'd0);
`endif
    applyStimulus("ovf8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef SOMA_OVERFLOW_EN
    checkOutput("ovf8080_V", {31'd0, V}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
